// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its debouncer.
// Frame results are a kind tag plus the key code, which is only meaningful for RES_KEY.
package keypad_pkg;

    localparam int NIBBLES = 6;
    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hB;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_t;

    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] key;
    } frame_res_t;

    // Bit i of hits is row i[3:2], column i[1:0], so a lone hit's index is the key code.
    // The key field is forced to zero unless exactly one bit is set, so whole-struct
    // equality is a valid "same result" test.
    function automatic frame_res_t classify(input logic [15:0] hits);
        frame_res_t res;
        int         n;
        res.kind = RES_NONE;
        res.key  = 4'd0;
        n        = 0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) begin
                n++;
                res.key = 4'(i);
            end
        end
        if (n == 1) begin
            res.kind = RES_KEY;
        end else if (n > 1) begin
            res.kind = RES_MULTI;
            res.key  = 4'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: a result must repeat DEBOUNCE frames before it is adopted.
// A NONE->KEY adoption raises a one-cycle press strobe; KEYPAD_REPEAT_EN adds auto-repeat.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  frame_res_t res,
    output frame_res_t db_res,
    output logic       press
);

    localparam logic [3:0] DB_N = 4'(DEBOUNCE);

    if (DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
        $error("keypad_debounce: parameter out of range");
    end

    frame_res_t prev;
    frame_res_t state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       press_next;
    logic       event_next;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_next   = cnt;
        state_next = db_res;
        press_next = 1'b0;
        if (frame_tick) begin
            if (res == prev) begin
                cnt_next = (cnt < DB_N) ? cnt + 4'd1 : cnt;
            end else begin
                cnt_next = 4'd1;
            end
            if (cnt_next == DB_N) begin
                state_next = res;
            end
            press_next = (db_res.kind == RES_NONE) && (state_next.kind == RES_KEY);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] rep_cnt;
    logic       rep_first;
    logic       armed;
    logic       rep_fire;

    // Only a genuine press arms the repeater, so a key left over from MULTI never repeats.
    always_comb begin
        rep_fire = 1'b0;
        if (frame_tick && armed && (state_next == db_res)) begin
            rep_fire = (rep_cnt + 8'd1) ==
                       (rep_first ? 8'(REPEAT_DELAY) : 8'(REPEAT_RATE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= 8'd0;
            rep_first <= 1'b1;
            armed     <= 1'b0;
        end else if (frame_tick) begin
            if (state_next != db_res) begin
                rep_cnt   <= 8'd0;
                rep_first <= 1'b1;
                armed     <= press_next;
            end else if (rep_fire) begin
                rep_cnt   <= 8'd0;
                rep_first <= 1'b0;
            end else if (armed) begin
                rep_cnt <= rep_cnt + 8'd1;
            end
        end
    end

    assign event_next = press_next | rep_fire;
`else
    assign event_next = press_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= '{kind: RES_NONE, key: 4'd0};
            db_res <= '{kind: RES_NONE, key: 4'd0};
            cnt    <= 4'd0;
            press  <= 1'b0;
        end else begin
            if (frame_tick) begin
                prev <= res;
            end
            cnt    <= cnt_next;
            db_res <= state_next;
            press  <= event_next;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix scanner with debounced key events and a six-nibble entry register.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd1024,
    parameter int          DEBOUNCE     = 4,
    parameter int          REPEAT_DELAY = 64,
    parameter int          REPEAT_RATE  = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [3:0]             iCol,
    input  logic                   iIsHex,
    output logic [3:0]             oRow,
    output logic [3:0]             oKey,
    output logic                   oKeyValid,
    output logic                   oPressed,
    output logic [4*NIBBLES-1:0]   oNum
);

    if (SCAN_DIV < 16'd2) begin : g_bad_div
        $error("keypad_scan: SCAN_DIV must be at least 2");
    end

    logic [15:0]      slot;
    logic [1:0]       row;
    logic [2:0][3:0]  hits;
    logic             slot_last;
    logic             frame_tick;
    frame_res_t       res;
    frame_res_t       db_res;
    logic             press;

    assign slot_last  = (slot == SCAN_DIV - 16'd1);
    assign frame_tick = slot_last && (row == 2'd3);
    assign oRow       = ~(4'b0001 << row);

    // Row 3 is classified straight from the pins on the same edge it is sampled.
    assign res = classify({~iCol, hits});

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            slot <= 16'd0;
            row  <= 2'd0;
            hits <= '0;
        end else if (slot_last) begin
            slot <= 16'd0;
            row  <= row + 2'd1;
            case (row)
                2'd0:    hits[0] <= ~iCol;
                2'd1:    hits[1] <= ~iCol;
                2'd2:    hits[2] <= ~iCol;
                default: ;
            endcase
        end else begin
            slot <= slot + 16'd1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_debounce (
        .clk        (iCLK),
        .rst        (iRST),
        .frame_tick (frame_tick),
        .res        (res),
        .db_res     (db_res),
        .press      (press)
    );

    assign oPressed = (db_res.kind == RES_KEY);

    // Hex mode shifts in every key; decimal mode reserves A/B for edit commands.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oKeyValid <= 1'b0;
            oKey      <= 4'd0;
            oNum      <= '0;
        end else begin
            oKeyValid <= press;
            if (press) begin
                oKey <= db_res.key;
                if (iIsHex || db_res.key <= 4'd9) begin
                    oNum <= {oNum[4*NIBBLES-5:0], db_res.key};
                end else if (db_res.key == KEY_CLR) begin
                    oNum <= '0;
                end else if (db_res.key == KEY_BS) begin
                    oNum <= {4'h0, oNum[4*NIBBLES-1:4]};
                end
            end
        end
    end

endmodule
